// File: rtl/pipe_hazard_if.sv
// ============================================================================
// Interface     : pipe_hazard_if
// Description   : Bundles every signal between the 5-stage pipeline datapath
//                 and the hazard controller.
//                 master : pipeline side. Drives stage register fields and
//                          memory handshake, receives enables/flushes/selects.
//                 slave  : hazard controller side.
// Parameters    : CNT_W - width of the stall-cycle performance counter
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    // Pipeline -> controller
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_jump;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic             mem_req;
    logic             mem_ready;

    // Controller -> pipeline
    logic             pc_ld;
    logic             if_id_ld;
    logic             if_id_flush;
    logic             id_ex_ld;
    logic             id_ex_flush;
    logic             ex_mem_ld;
    logic             mem_wb_ld;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_jump, ex_rs, ex_rt, ex_rd, ex_mem_read,
               ex_branch_taken, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               mem_req, mem_ready,
        input  pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_flush,
               ex_mem_ld, mem_wb_ld, fwd_a, fwd_b, state, mem_timeout,
               stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_jump, ex_rs, ex_rt, ex_rd, ex_mem_read,
               ex_branch_taken, mem_rd, mem_reg_write, wb_rd, wb_reg_write,
               mem_req, mem_ready,
        output pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_flush,
               ex_mem_ld, mem_wb_ld, fwd_a, fwd_b, state, mem_timeout,
               stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module        : pipe_hazard_ctrl
// Description   : Central hazard sequencer for the 5-stage MIPS pipeline.
//                 Generates stage load enables / flush strobes and EX-stage
//                 forwarding selects. Priority: memory-wait freeze, taken
//                 branch flush, load-use stall, jump flush. An FSM tracks
//                 data-memory waits and raises a sticky timeout.
// Ports         : clk       - clock
//                 rst       - asynchronous active-high reset
//                 hz        - pipe_hazard_if.slave (all pipeline signals)
// Parameters    : MAX_WAIT  - wait cycles tolerated before timeout (>=1)
//                 CNT_W     - width of stall_cycles
// Macro         : HAZ_PERF_CNT_EN - when defined, stall_cycles is a real
//                 saturating counter; otherwise it is tied to zero.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    pipe_hazard_if.slave hz
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              timeout_q;
    logic              freeze;

    // ------------------------------------------------------------------
    // Forwarding: MEM result is younger than WB, so it wins. Register 0
    // is hard-wired zero and never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        hz.fwd_a = 2'b00;
        hz.fwd_b = 2'b00;
        if (!rst) begin
            if (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rs)
                hz.fwd_a = 2'b10;
            else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rs)
                hz.fwd_a = 2'b01;

            if (hz.mem_reg_write && hz.mem_rd != 5'd0 && hz.mem_rd == hz.ex_rt)
                hz.fwd_b = 2'b10;
            else if (hz.wb_reg_write && hz.wb_rd != 5'd0 && hz.wb_rd == hz.ex_rt)
                hz.fwd_b = 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Stage control. The freeze covers the very first cycle of an access
    // (still in RUN) so nothing moves before the FSM reaches MEM_WAIT.
    // ------------------------------------------------------------------
    assign freeze = ((state_q == ST_MEM_WAIT) && !hz.mem_ready) ||
                    ((state_q == ST_RUN) && hz.mem_req && !hz.mem_ready);

    always_comb begin
        hz.pc_ld       = 1'b0;
        hz.if_id_ld    = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.id_ex_ld    = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.ex_mem_ld   = 1'b0;
        hz.mem_wb_ld   = 1'b0;
        if (!rst && state_q != ST_ERR && !freeze) begin
            hz.pc_ld     = 1'b1;
            hz.if_id_ld  = 1'b1;
            hz.id_ex_ld  = 1'b1;
            hz.ex_mem_ld = 1'b1;
            hz.mem_wb_ld = 1'b1;
            if (hz.ex_branch_taken) begin
                // Instruction in ID is discarded, so its load-use is moot.
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (hz.ex_mem_read && hz.ex_rd != 5'd0 &&
                         (hz.ex_rd == hz.id_rs || hz.ex_rd == hz.id_rt)) begin
                // Hold PC and IF/ID one cycle; the load moves on to MEM so
                // the match disappears next cycle, giving exactly one bubble.
                hz.pc_ld       = 1'b0;
                hz.if_id_ld    = 1'b0;
                hz.id_ex_flush = 1'b1;
            end else if (hz.id_jump) begin
                hz.if_id_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM. ERR is terminal until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hz.mem_req && !hz.mem_ready) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                        state_q   <= ST_ERR;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign hz.state       = state_q;
    assign hz.mem_timeout = timeout_q;

    // ------------------------------------------------------------------
    // Stall statistics: non-advancing cycles plus inserted bubbles.
    // ------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;
    logic             stall_evt;

    assign stall_evt = !hz.pc_ld || hz.if_id_flush || hz.id_ex_flush;

    always_comb begin
        stall_d = stall_q;
        if (stall_evt && stall_q != {CNT_W{1'b1}})
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign hz.stall_cycles = stall_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module        : tb_pipe_hazard_ctrl
// Description   : Directed self-checking bench for pipe_hazard_ctrl
//                 (MAX_WAIT=4). Checks reset, forwarding, load-use, branch,
//                 jump, memory wait, timeout and asynchronous reset.
// Revision      : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 16;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_ld, if_id_ld, if_id_flush, id_ex_ld, id_ex_flush, ex_mem_ld, mem_wb_ld}
    localparam logic [6:0] C_FRZ  = 7'b0000000;
    localparam logic [6:0] C_NORM = 7'b1101011;
    localparam logic [6:0] C_LU   = 7'b0001111;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_JMP  = 7'b1111011;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_MW  = 2'b01;
    localparam logic [1:0] S_ERR = 2'b10;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;

    pipe_hazard_if #(.CNT_W(CNT_W)) hz();

    pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    logic [6:0] ctl;
    assign ctl = {hz.pc_ld, hz.if_id_ld, hz.if_id_flush, hz.id_ex_ld,
                  hz.id_ex_flush, hz.ex_mem_ld, hz.mem_wb_ld};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stall_exp();
        return PERF ? 32'(exp_stall) : 32'd0;
    endfunction

    task automatic clear_inputs();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_jump = 1'b0;
        hz.ex_rs = 5'd0; hz.ex_rt = 5'd0; hz.ex_rd = 5'd0;
        hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
        hz.mem_rd = 5'd0; hz.mem_reg_write = 1'b0;
        hz.wb_rd = 5'd0; hz.wb_reg_write = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    endtask

    // Inputs are applied just after a rising edge; this checks the cycle,
    // crosses the next edge and accounts the expected stall event.
    task automatic step(input string tag, input logic [6:0] exp_ctl, input logic [1:0] exp_st);
        #1;
        check({tag, ".ctl"},   32'(ctl),             32'(exp_ctl));
        check({tag, ".state"}, 32'(hz.state),        32'(exp_st));
        check({tag, ".stall"}, 32'(hz.stall_cycles), stall_exp());
        @(posedge clk);
        #1;
        if (!exp_ctl[6] || exp_ctl[4] || exp_ctl[2])
            exp_stall++;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Forwarding match present during reset must still read 00.
        hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd5; hz.ex_rs = 5'd5;
        #2;
        check("rst.ctl",     32'(ctl),             32'(C_FRZ));
        check("rst.state",   32'(hz.state),        32'(S_RUN));
        check("rst.fwd_a",   32'(hz.fwd_a),        32'd0);
        check("rst.timeout", 32'(hz.mem_timeout),  32'd0);
        check("rst.stall",   32'(hz.stall_cycles), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        step("idle", C_NORM, S_RUN);

        // Forwarding
        hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd5;
        hz.wb_reg_write  = 1'b1; hz.wb_rd  = 5'd5;
        hz.ex_rs = 5'd5; hz.ex_rt = 5'd5;
        #1;
        check("fwd1.a", 32'(hz.fwd_a), 32'd2);
        check("fwd1.b", 32'(hz.fwd_b), 32'd2);
        hz.mem_reg_write = 1'b0;
        #1;
        check("fwd2.a", 32'(hz.fwd_a), 32'd1);
        check("fwd2.b", 32'(hz.fwd_b), 32'd1);
        hz.mem_reg_write = 1'b1; hz.mem_rd = 5'd0; hz.ex_rs = 5'd0;
        #1;
        check("fwd3.a", 32'(hz.fwd_a), 32'd0);
        check("fwd3.b", 32'(hz.fwd_b), 32'd1);
        @(posedge clk); #1;
        clear_inputs();

        // Load-use: one bubble, then free-running
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd3; hz.id_rt = 5'd3;
        step("lu", C_LU, S_RUN);
        hz.ex_mem_read = 1'b0;
        step("lu_after", C_NORM, S_RUN);

        // Branch beats load-use
        hz.ex_mem_read = 1'b1; hz.ex_branch_taken = 1'b1;
        step("br_lu", C_BR, S_RUN);
        clear_inputs();

        // Jump, then jump held behind a load-use stall
        hz.id_jump = 1'b1;
        step("jmp", C_JMP, S_RUN);
        hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs = 5'd7;
        step("jmp_lu", C_LU, S_RUN);
        hz.ex_mem_read = 1'b0;
        step("jmp_after", C_JMP, S_RUN);
        clear_inputs();

        // Memory wait of 3 frozen cycles, then completion
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        step("mw0", C_FRZ, S_RUN);
        step("mw1", C_FRZ, S_MW);
        step("mw2", C_FRZ, S_MW);
        hz.mem_ready = 1'b1;
        step("mw_done", C_NORM, S_MW);
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        step("mw_back", C_NORM, S_RUN);

        // Single-cycle access
        hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
        step("single", C_NORM, S_RUN);
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
        step("single_after", C_NORM, S_RUN);

        // Timeout with MAX_WAIT=4
        hz.mem_req = 1'b1;
        step("to0", C_FRZ, S_RUN);
        step("to1", C_FRZ, S_MW);
        step("to2", C_FRZ, S_MW);
        step("to3", C_FRZ, S_MW);
        step("to4", C_FRZ, S_MW);
        check("to.timeout_set", 32'(hz.mem_timeout), 32'd1);
        step("to_err", C_FRZ, S_ERR);
        hz.mem_req = 1'b0; hz.mem_ready = 1'b1;
        hz.wb_reg_write = 1'b1; hz.wb_rd = 5'd9; hz.ex_rs = 5'd9;
        step("err_hold", C_FRZ, S_ERR);
        check("err.timeout", 32'(hz.mem_timeout), 32'd1);
        check("err.fwd_a",   32'(hz.fwd_a),       32'd1);
        clear_inputs();

        // Reset clears ERR
        rst = 1'b1;
        #1;
        check("rst_err.state",   32'(hz.state),        32'(S_RUN));
        check("rst_err.timeout", 32'(hz.mem_timeout),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_stall = 0;
        step("post_rst", C_NORM, S_RUN);

        // Asynchronous reset in the middle of a wait
        hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
        step("amw0", C_FRZ, S_RUN);
        step("amw1", C_FRZ, S_MW);
        #2;
        rst = 1'b1;
        #1;
        check("arst.state",   32'(hz.state),        32'(S_RUN));
        check("arst.ctl",     32'(ctl),             32'(C_FRZ));
        check("arst.stall",   32'(hz.stall_cycles), 32'd0);
        check("arst.timeout", 32'(hz.mem_timeout),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        exp_stall = 0;
        step("arst_after", C_NORM, S_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
